// File: rtl/fp_div_if.sv
// Handshake bundle for fp_div: operand request side and result response side.
interface fp_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] q;
  logic                  div_by_zero;
  logic                  overflow;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero, overflow
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero, overflow
  );
endinterface

// File: rtl/fp_div.sv
// Sequential signed fixed-point divider (restoring, one quotient bit per clock)
// with saturation and divide-by-zero flagging.
module fp_div #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic     clk,
  input  logic     rst,
  fp_div_if.slave  bus
);
  localparam int QW = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

  state_t                state;
  logic                  sign;
  logic                  zero_div;
  logic [DATA_WIDTH-1:0] bmag;
  logic [DATA_WIDTH:0]   rem;
  logic [QW-1:0]         dq;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [DATA_WIDTH:0]   rem_sh;
  logic                  fits;
  logic                  pos_ovf;
  logic                  neg_ovf;
  logic [DATA_WIDTH-1:0] mag_lo;

  assign bus.in_ready = (state == IDLE) && !rst;

  always_comb begin
    a_mag   = bus.a[DATA_WIDTH-1] ? -bus.a : bus.a;
    b_mag   = bus.b[DATA_WIDTH-1] ? -bus.b : bus.b;
    rem_sh  = {rem[DATA_WIDTH-1:0], dq[QW-1]};
    fits    = rem_sh >= {1'b0, bmag};
    mag_lo  = dq[DATA_WIDTH-1:0];
    pos_ovf = |dq[QW-1:DATA_WIDTH-1];
    // Negative side may reach exactly 2^(DATA_WIDTH-1) without saturating.
    neg_ovf = (|dq[QW-1:DATA_WIDTH]) || (dq[DATA_WIDTH-1] && (|dq[DATA_WIDTH-2:0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sign            <= 1'b0;
      zero_div        <= 1'b0;
      bmag            <= '0;
      rem             <= '0;
      dq              <= '0;
      cnt             <= '0;
      bus.out_valid   <= 1'b0;
      bus.q           <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign     <= bus.a[DATA_WIDTH-1] ^ bus.b[DATA_WIDTH-1];
            bmag     <= b_mag;
            dq       <= {a_mag, {FRAC_BITS{1'b0}}};
            rem      <= '0;
            cnt      <= '0;
            zero_div <= (bus.b == '0);
            state    <= (bus.b == '0) ? FINAL : CALC;
          end
        end
        CALC: begin
          // Dividend bits shift out the top while quotient bits fill the bottom.
          rem   <= fits ? (rem_sh - {1'b0, bmag}) : rem_sh;
          dq    <= {dq[QW-2:0], fits};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(QW - 1)) state <= FINAL;
        end
        FINAL: begin
          bus.out_valid <= 1'b1;
          state         <= DONE;
          if (zero_div) begin
            bus.q           <= sign ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            bus.div_by_zero <= 1'b1;
            bus.overflow    <= 1'b0;
          end else if (!sign && pos_ovf) begin
            bus.q           <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b1;
          end else if (sign && neg_ovf) begin
            bus.q           <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b1;
          end else begin
            bus.q           <= sign ? -mag_lo : mag_lo;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
